// File: rtl/pipe_skid_latch.sv
// ---------------------------------------------------------------------------
// pipe_skid_latch
//
// Elastic pipeline latch between two processor stages. Each entry carries a
// PC and an instruction word. Storage is one main entry, which drives the
// outputs directly, plus one skid entry. The skid entry catches the word the
// upstream stage was already committed to sending in the cycle the
// downstream stage stalled. Because of the skid entry, in_ready can be a
// pure register decode and still sustain one word per cycle.
//
// Optional feature macro: STALL_COUNT_EN
//   When defined, adds the stall_count output. stall_count counts the cycles
//   with out_valid & !out_ready and saturates at all-ones. Only clr clears
//   it; flush leaves it alone.
//
// Parameters
//   DATA_WIDTH   width of each carried field (pc, insn)
//
// Ports
//   clk          rising-edge clock
//   clr          asynchronous, active-high reset
//   flush        synchronous squash of every held entry
//   in_valid     upstream presents in_pc / in_insn
//   in_ready     latch can accept this cycle (registered decode)
//   in_pc        upstream PC
//   in_insn      upstream instruction
//   out_valid    out_pc / out_insn hold a live entry
//   out_ready    downstream consumes this cycle
//   out_pc       head-entry PC
//   out_insn     head-entry instruction
//   stall_count  (STALL_COUNT_EN only) number of stall cycles seen
// ---------------------------------------------------------------------------
module pipe_skid_latch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_insn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_insn
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  // Occupancy of the latch. EMPTY: nothing held. BUSY: main entry only.
  // FULL: main and skid entries both hold live words.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } latchState_t;

  latchState_t           r_state;

  // Main entry. Its flops feed the outputs directly.
  logic                  r_mainValid;
  logic [DATA_WIDTH-1:0] r_mainPc;
  logic [DATA_WIDTH-1:0] r_mainInsn;

  // Skid entry. It holds a word only in FULL.
  logic                  r_skidValid;
  logic [DATA_WIDTH-1:0] r_skidPc;
  logic [DATA_WIDTH-1:0] r_skidInsn;

  logic                  w_accept;
  logic                  w_take;

  // in_ready depends only on the skid valid flop. This keeps out_ready off
  // any combinational path back to the upstream stage.
  assign in_ready  = !r_skidValid;

  assign out_valid = r_mainValid;
  assign out_pc    = r_mainPc;
  assign out_insn  = r_mainInsn;

  assign w_accept  = in_valid && !r_skidValid;
  assign w_take    = r_mainValid && out_ready;

  // Occupancy FSM and entry storage.
  // flush overrides every handshake. It drops the word being offered and
  // clears both valid bits. A take in the same cycle still completes, because
  // the downstream stage has already seen the head word. Data flops are not
  // cleared on flush because nothing reads them while their valid bit is low.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= EMPTY;
      r_mainValid <= 1'b0;
      r_mainPc    <= '0;
      r_mainInsn  <= '0;
      r_skidValid <= 1'b0;
      r_skidPc    <= '0;
      r_skidInsn  <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_mainPc    <= in_pc;
            r_mainInsn  <= in_insn;
            r_mainValid <= 1'b1;
            r_state     <= BUSY;
          end
        end

        BUSY: begin
          if (w_accept && w_take) begin
            // Head leaves and the new word replaces it in the same cycle.
            r_mainPc   <= in_pc;
            r_mainInsn <= in_insn;
          end else if (w_accept) begin
            // Downstream stalled while upstream was still sending.
            // The skid entry catches the new word.
            r_skidPc    <= in_pc;
            r_skidInsn  <= in_insn;
            r_skidValid <= 1'b1;
            r_state     <= FULL;
          end else if (w_take) begin
            r_mainValid <= 1'b0;
            r_state     <= EMPTY;
          end
        end

        FULL: begin
          // in_ready is low here, so input activity is ignored. Only a take
          // moves anything: the skid word becomes the head (FIFO order).
          if (w_take) begin
            r_mainPc    <= r_skidPc;
            r_mainInsn  <= r_skidInsn;
            r_skidValid <= 1'b0;
            r_state     <= BUSY;
          end
        end

        default: begin
          r_state     <= EMPTY;
          r_mainValid <= 1'b0;
          r_skidValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] r_stallCount;

  // Counts cycles where a live head entry is refused by downstream.
  // Saturates instead of wrapping. flush deliberately leaves it untouched.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stallCount <= '0;
    end else if (r_mainValid && !out_ready && (r_stallCount != 32'hFFFF_FFFF)) begin
      r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign stall_count = r_stallCount;
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_latch
//
// Directed testbench for pipe_skid_latch. Inputs change on the falling clock
// edge and outputs are sampled on the falling edge, half a cycle after the
// rising edge that produced them. Each instruction word is derived from its
// PC so that a mixed-up pairing of pc and insn shows up in the checks.
// Define STALL_COUNT_EN to also exercise the stall counter.
// ---------------------------------------------------------------------------
module tb_pipe_skid_latch;

  localparam int DW = 32;

  logic          clk;
  logic          clr;
  logic          flush;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inPc;
  logic [DW-1:0] inInsn;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outPc;
  logic [DW-1:0] outInsn;
`ifdef STALL_COUNT_EN
  logic [31:0]   stallCount;
`endif

  int errCount   = 0;
  int checkCount = 0;

  pipe_skid_latch #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_pc     (inPc),
    .in_insn   (inInsn),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_pc    (outPc),
    .out_insn  (outInsn)
`ifdef STALL_COUNT_EN
    ,
    .stall_count (stallCount)
`endif
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word paired with each PC.
  function automatic logic [DW-1:0] insnOf(input logic [DW-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Drives the upstream, downstream and flush inputs for the next edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] pc,
                               input logic rdy, input logic fl);
    inValid  = v;
    inPc     = pc;
    inInsn   = insnOf(pc);
    outReady = rdy;
    flush    = fl;
  endtask

  // Compares one data-width output against its expected value.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    assert (observed === expected)
      else begin
        errCount++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Compares one single-bit output against its expected value.
  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checkCount++;
    assert (observed === expected)
      else begin
        errCount++;
        $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  // Directed sequence. Each @(negedge clk) is half a cycle after the
  // previous rising edge.
  initial begin
    clr = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2 clr = 1'b1;
    #1;
    checkFlag("rst_out_valid", outValid, 1'b0);
    checkFlag("rst_in_ready", inReady, 1'b1);
    checkOutput("rst_out_pc", outPc, 32'h0);
    checkOutput("rst_out_insn", outInsn, 32'h0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;

    // Streaming with out_ready high: one word per cycle, 1-cycle latency.
    $display("[TB] streaming");
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stream_pc0", outPc, 32'h0);
    checkFlag("stream_valid0", outValid, 1'b1);
    checkFlag("stream_ready0", inReady, 1'b1);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stream_pc4", outPc, 32'h4);
    checkOutput("stream_insn4", outInsn, insnOf(32'h4));
    checkFlag("stream_ready1", inReady, 1'b1);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stream_pc8", outPc, 32'h8);
    checkFlag("stream_ready2", inReady, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkFlag("stream_drained", outValid, 1'b0);

    // Backpressure: 0x10 held, 0x14 in skid, 0x18 refused then re-offered.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_head10", outPc, 32'h10);
    checkFlag("bp_ready_busy", inReady, 1'b1);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_hold10", outPc, 32'h10);
    checkFlag("bp_ready_full", inReady, 1'b0);
    applyStimulus(1'b1, 32'h18, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_still10", outPc, 32'h10);
    checkOutput("bp_insn10", outInsn, insnOf(32'h10));
    checkFlag("bp_still_full", inReady, 1'b0);
    applyStimulus(1'b1, 32'h18, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_pop14", outPc, 32'h14);
    checkOutput("bp_insn14", outInsn, insnOf(32'h14));
    checkFlag("bp_ready_after_pop", inReady, 1'b1);
    @(negedge clk);
    checkOutput("bp_pop18", outPc, 32'h18);
    checkFlag("bp_valid18", outValid, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkFlag("bp_drained", outValid, 1'b0);

    // Flush while FULL, with 0x20 offered in the flush cycle.
    $display("[TB] flush");
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0);
    @(negedge clk);
    checkFlag("fl_full", inReady, 1'b0);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
    @(negedge clk);
    checkFlag("fl_out_valid", outValid, 1'b0);
    checkFlag("fl_in_ready", inReady, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkFlag("fl_no_ghost", outValid, 1'b0);

    // Accept and take together in BUSY.
    $display("[TB] accept+take");
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("at_head30", outPc, 32'h30);
    applyStimulus(1'b1, 32'h34, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("at_head34", outPc, 32'h34);
    checkFlag("at_valid", outValid, 1'b1);
    checkFlag("at_in_ready", inReady, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkFlag("at_drained", outValid, 1'b0);

    // Asynchronous clr mid-run while FULL.
    $display("[TB] clr mid-run");
    applyStimulus(1'b1, 32'h50, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h54, 1'b0, 1'b0);
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    checkFlag("clr_out_valid", outValid, 1'b0);
    checkOutput("clr_out_pc", outPc, 32'h0);
    checkOutput("clr_out_insn", outInsn, 32'h0);
    checkFlag("clr_in_ready", inReady, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checkFlag("clr_after_valid", outValid, 1'b0);
    checkFlag("clr_after_ready", inReady, 1'b1);

`ifdef STALL_COUNT_EN
    // Stall counter: 5 stalled edges, then a flush with out_ready high.
    $display("[TB] stall counter");
    checkOutput("sc_zero", stallCount, 32'd0);
    applyStimulus(1'b1, 32'h60, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    checkOutput("sc_five", stallCount, 32'd5);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("sc_after_flush", stallCount, 32'd5);
    @(negedge clk);
    checkOutput("sc_hold", stallCount, 32'd5);
    #2 clr = 1'b1;
    #1;
    checkOutput("sc_clr", stallCount, 32'd0);
    @(negedge clk);
    clr = 1'b0;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
